// File: rtl/nic_input_arbiter.sv
// nic_input_arbiter: five-input round-robin packet arbiter. It merges AXI-Stream
// slaves into one registered master stream and stamps the source port on the first beat.
// Ports: axi_aclk, axi_reset (async, active-high).
// Ports: s_axis_{0..4}_* are the slave streams. m_axis_* is the merged stream.
module nic_input_arbiter #(
  parameter int C_DATA_WIDTH  = 64,
  parameter int C_TUSER_WIDTH = 128
) (
  input  logic                       axi_aclk,
  input  logic                       axi_reset,
  input  logic [C_DATA_WIDTH-1:0]    s_axis_0_tdata,
  input  logic [C_DATA_WIDTH/8-1:0]  s_axis_0_tstrb,
  input  logic [C_TUSER_WIDTH-1:0]   s_axis_0_tuser,
  input  logic                       s_axis_0_tvalid,
  input  logic                       s_axis_0_tlast,
  output logic                       s_axis_0_tready,
  input  logic [C_DATA_WIDTH-1:0]    s_axis_1_tdata,
  input  logic [C_DATA_WIDTH/8-1:0]  s_axis_1_tstrb,
  input  logic [C_TUSER_WIDTH-1:0]   s_axis_1_tuser,
  input  logic                       s_axis_1_tvalid,
  input  logic                       s_axis_1_tlast,
  output logic                       s_axis_1_tready,
  input  logic [C_DATA_WIDTH-1:0]    s_axis_2_tdata,
  input  logic [C_DATA_WIDTH/8-1:0]  s_axis_2_tstrb,
  input  logic [C_TUSER_WIDTH-1:0]   s_axis_2_tuser,
  input  logic                       s_axis_2_tvalid,
  input  logic                       s_axis_2_tlast,
  output logic                       s_axis_2_tready,
  input  logic [C_DATA_WIDTH-1:0]    s_axis_3_tdata,
  input  logic [C_DATA_WIDTH/8-1:0]  s_axis_3_tstrb,
  input  logic [C_TUSER_WIDTH-1:0]   s_axis_3_tuser,
  input  logic                       s_axis_3_tvalid,
  input  logic                       s_axis_3_tlast,
  output logic                       s_axis_3_tready,
  input  logic [C_DATA_WIDTH-1:0]    s_axis_4_tdata,
  input  logic [C_DATA_WIDTH/8-1:0]  s_axis_4_tstrb,
  input  logic [C_TUSER_WIDTH-1:0]   s_axis_4_tuser,
  input  logic                       s_axis_4_tvalid,
  input  logic                       s_axis_4_tlast,
  output logic                       s_axis_4_tready,
  output logic [C_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                       m_axis_tvalid,
  output logic                       m_axis_tlast,
  input  logic                       m_axis_tready
);

  localparam int SW = C_DATA_WIDTH / 8;

  typedef enum logic {IDLE, PKT} state_t;

  state_t                     state_q, state_d;
  logic [2:0]                 grant_q, grant_d;
  logic [2:0]                 ptr_q, ptr_d;
  logic                       first_q, first_d;
  logic [C_DATA_WIDTH-1:0]    tdata_q, tdata_d;
  logic [SW-1:0]              tstrb_q, tstrb_d;
  logic [C_TUSER_WIDTH-1:0]   tuser_q, tuser_d;
  logic                       tvalid_q, tvalid_d;
  logic                       tlast_q, tlast_d;

  logic [C_DATA_WIDTH-1:0]    s_tdata [5];
  logic [SW-1:0]              s_tstrb [5];
  logic [C_TUSER_WIDTH-1:0]   s_tuser [5];
  logic [4:0]                 s_tvalid;
  logic [4:0]                 s_tlast;
  logic [4:0]                 s_tready;

  logic       out_free;
  logic       xfer;
  logic       found;
  logic [2:0] sel;

  assign s_tdata[0] = s_axis_0_tdata;
  assign s_tdata[1] = s_axis_1_tdata;
  assign s_tdata[2] = s_axis_2_tdata;
  assign s_tdata[3] = s_axis_3_tdata;
  assign s_tdata[4] = s_axis_4_tdata;
  assign s_tstrb[0] = s_axis_0_tstrb;
  assign s_tstrb[1] = s_axis_1_tstrb;
  assign s_tstrb[2] = s_axis_2_tstrb;
  assign s_tstrb[3] = s_axis_3_tstrb;
  assign s_tstrb[4] = s_axis_4_tstrb;
  assign s_tuser[0] = s_axis_0_tuser;
  assign s_tuser[1] = s_axis_1_tuser;
  assign s_tuser[2] = s_axis_2_tuser;
  assign s_tuser[3] = s_axis_3_tuser;
  assign s_tuser[4] = s_axis_4_tuser;
  assign s_tvalid = {s_axis_4_tvalid, s_axis_3_tvalid, s_axis_2_tvalid,
                     s_axis_1_tvalid, s_axis_0_tvalid};
  assign s_tlast  = {s_axis_4_tlast, s_axis_3_tlast, s_axis_2_tlast,
                     s_axis_1_tlast, s_axis_0_tlast};

  assign s_axis_0_tready = s_tready[0];
  assign s_axis_1_tready = s_tready[1];
  assign s_axis_2_tready = s_tready[2];
  assign s_axis_3_tready = s_tready[3];
  assign s_axis_4_tready = s_tready[4];

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tstrb  = tstrb_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;

  // Reduce a value in 0..9 to an input index in 0..4.
  function automatic logic [2:0] wrap5(input logic [3:0] v);
    return (v >= 4'd5) ? 3'(v - 4'd5) : v[2:0];
  endfunction

  // Source-port code that is stamped into tuser[23:16] on the first beat.
  function automatic logic [7:0] src_code(input logic [2:0] idx);
    case (idx)
      3'd0:    src_code = 8'h01;
      3'd1:    src_code = 8'h04;
      3'd2:    src_code = 8'h10;
      3'd3:    src_code = 8'h40;
      3'd4:    src_code = 8'h02;
      default: src_code = 8'h00;
    endcase
  endfunction

  // Round-robin search that starts at ptr.
  always_comb begin
    found = 1'b0;
    sel   = 3'd0;
    for (int k = 0; k < 5; k++) begin
      if (!found && s_tvalid[wrap5({1'b0, ptr_q} + 4'(k))]) begin
        found = 1'b1;
        sel   = wrap5({1'b0, ptr_q} + 4'(k));
      end
    end
  end

  // The single output register can take a beat when it is empty or draining.
  always_comb begin
    out_free = !tvalid_q || m_axis_tready;
    s_tready = '0;
    if (state_q == PKT && out_free) s_tready[grant_q] = 1'b1;
    xfer = (state_q == PKT) && out_free && s_tvalid[grant_q];
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    first_d = first_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = sel;
          first_d = 1'b1;
          state_d = PKT;
        end
      end
      PKT: begin
        if (xfer) begin
          first_d = 1'b0;
          if (s_tlast[grant_q]) begin
            state_d = IDLE;
            ptr_d   = wrap5({1'b0, grant_q} + 4'd1);
          end
        end
      end
    endcase
  end

  always_comb begin
    tdata_d  = tdata_q;
    tstrb_d  = tstrb_q;
    tuser_d  = tuser_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    if (xfer) begin
      tdata_d  = s_tdata[grant_q];
      tstrb_d  = s_tstrb[grant_q];
      tuser_d  = s_tuser[grant_q];
      tlast_d  = s_tlast[grant_q];
      tvalid_d = 1'b1;
      if (first_q) tuser_d[23:16] = src_code(grant_q);
    end else if (tvalid_q && m_axis_tready) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      ptr_q    <= '0;
      first_q  <= 1'b0;
      tdata_q  <= '0;
      tstrb_q  <= '0;
      tuser_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      first_q  <= first_d;
      tdata_q  <= tdata_d;
      tstrb_q  <= tstrb_d;
      tuser_q  <= tuser_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
    end
  end

endmodule

// File: doc/nic_input_arbiter.md
NIC_INPUT_ARBITER -- requirements
Module: nic_input_arbiter

Interface
REQ-001 SHALL have parameter C_DATA_WIDTH, default 64, tdata width of all streams.
REQ-002 SHALL have parameter C_TUSER_WIDTH, default 128, tuser width of all streams.
REQ-003 SHALL have port axi_aclk  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port axi_reset  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports s_axis_i_tdata  in  C_DATA_WIDTH  slave data, for i = 0..4.
REQ-006 SHALL have ports s_axis_i_tstrb  in  C_DATA_WIDTH/8  byte strobes, i = 0..4.
REQ-007 SHALL have ports s_axis_i_tuser  in  C_TUSER_WIDTH  metadata: [15:0] length, [23:16] src port, i = 0..4.
REQ-008 SHALL have ports s_axis_i_tvalid / s_axis_i_tlast  in  1 each, and s_axis_i_tready  out  1, i = 0..4.
REQ-009 SHALL have ports m_axis_tdata / m_axis_tstrb / m_axis_tuser  out  same widths, merged stream to output port lookup.
REQ-010 SHALL have ports m_axis_tvalid, m_axis_tlast  out  1, and m_axis_tready  in  1.

Function
REQ-011 SHALL implement FSM states IDLE and PKT, plus registers grant[2:0], ptr[2:0], first_beat.
REQ-012 In IDLE, SHALL select the first input with tvalid=1 searching ptr, ptr+1, ... modulo 5, load grant, set first_beat=1, go to PKT next cycle.
REQ-013 In IDLE with no tvalid, SHALL stay in IDLE; all s_axis_i_tready = 0.
REQ-014 In PKT, SHALL drive s_axis_grant_tready = (!m_axis_tvalid || m_axis_tready); all other s_axis_i_tready = 0.
REQ-015 Output stage SHALL be one register: on slave transfer, load tdata/tstrb/tuser/tlast and set m_axis_tvalid=1 next cycle (latency 1 cycle).
REQ-016 When m_axis_tvalid && m_axis_tready with no new slave transfer, SHALL clear m_axis_tvalid; output SHALL hold stable while m_axis_tvalid && !m_axis_tready.
REQ-017 On first beat of a packet, SHALL overwrite tuser[23:16] with src code: input 0=0x01, 1=0x04, 2=0x10, 3=0x40, 4=0x02; other tuser bits unchanged; later beats pass tuser unchanged.
REQ-018 On slave transfer with tlast=1, SHALL return to IDLE and set ptr = grant+1, wrapping 4 -> 0.
REQ-019 Single-beat packet (tlast on first beat) SHALL be handled identically: stamped, then IDLE.
REQ-020 Granted input deasserting tvalid mid-packet SHALL NOT release grant; arbiter waits in PKT.
REQ-021 Other inputs' tvalid during PKT SHALL be ignored; their data never reaches m_axis.
REQ-022 Minimum gap between packets SHALL be one IDLE arbitration cycle; peak throughput one beat/cycle within a packet.
REQ-023 Bytes, beat order and tlast position SHALL be preserved exactly per packet; packets SHALL never interleave.

Reset
REQ-024 While axi_reset=1: state=IDLE, grant=0, ptr=0, first_beat=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata/tstrb/tuser=0, all s_axis_i_tready=0.
REQ-025 Reset mid-packet SHALL discard the partial packet and in-flight output beat; no tlast emitted for it; first arbitration after release starts at input 0.

Verification
REQ-026 Input 2 sends 34-beat packet, tuser=0x0004AAAA, m_axis_tready=1 -> m_axis emits 34 beats 1 cycle delayed, first tuser=0x0010AAAA, tlast on beat 34 only.
REQ-027 All five inputs valid with 3-beat packets from reset -> output packet order 0,1,2,3,4,0; one idle cycle between packets; no interleave.
REQ-028 Input 4 single-beat packet then input 0 waiting -> input 4 beat with tuser[23:16]=0x02 and tlast=1, ptr wraps to 0, input 0 served next.
REQ-029 m_axis_tready toggled 1010... during an 8-beat packet -> all 8 beats delivered in order, no duplicates or drops, output stable while stalled.
REQ-030 Granted input drops tvalid 5 cycles mid-packet while input 1 valid -> input 1 tready stays 0; packet completes from granted input first.
REQ-031 axi_reset asserted at beat 10 of a 32-beat packet -> m_axis_tvalid=0 and all tready=0 immediately; after release new packet on input 3 is arbitrated and forwarded intact.
